// File: rtl/operand_load_alu.sv
`default_nettype none
// ============================================================================
// Module      : operand_load_alu
// Description : Collects two 32-bit operands one switch byte per load press,
//               then runs a single registered ALU operation and holds it.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_load_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic        load_btn,
    input  logic [2:0]  alu_op,
    output logic [31:0] FOUT,
    output logic        ZF,
    output logic        OF,
    output logic [2:0]  byte_idx,
    output logic        done
);

    localparam logic [1:0] c_st_collect = 2'd0;
    localparam logic [1:0] c_st_exec    = 2'd1;
    localparam logic [1:0] c_st_hold    = 2'd2;

    localparam logic [2:0] c_op_and = 3'b000;
    localparam logic [2:0] c_op_or  = 3'b001;
    localparam logic [2:0] c_op_add = 3'b010;
    localparam logic [2:0] c_op_sub = 3'b011;
    localparam logic [2:0] c_op_slt = 3'b100;
    localparam logic [2:0] c_op_xor = 3'b101;
    localparam logic [2:0] c_op_nor = 3'b110;
    localparam logic [2:0] c_op_sll = 3'b111;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_load_q;
    logic        w_load_edge;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        w_capture;
    logic        w_exec;
    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic [31:0] w_result;
    logic        w_of;

    // load_q follows the button even during reset so a held press never edges
    always_ff @(posedge clk) begin
        r_load_q <= load_btn;
    end

    assign w_load_edge = load_btn & ~r_load_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_collect;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_collect: if (w_load_edge && byte_idx == 3'd7) w_state_nxt = c_st_exec;
            c_st_exec:    w_state_nxt = c_st_hold;
            c_st_hold:    if (w_load_edge) w_state_nxt = c_st_collect;
            default:      w_state_nxt = c_st_collect;
        endcase
    end

    always_comb begin
        w_capture = 1'b0;
        w_exec    = 1'b0;
        case (r_state)
            c_st_collect: w_capture = w_load_edge;
            c_st_exec:    w_exec    = 1'b1;
            c_st_hold:    w_capture = w_load_edge;
            default:      w_capture = 1'b0;
        endcase
    end

    assign w_sum  = r_a + r_b;
    assign w_diff = r_a - r_b;

    always_comb begin
        w_result = 32'd0;
        w_of     = 1'b0;
        case (alu_op)
            c_op_and: w_result = r_a & r_b;
            c_op_or:  w_result = r_a | r_b;
            c_op_add: begin
                w_result = w_sum;
                w_of     = (r_a[31] == r_b[31]) && (w_sum[31] != r_a[31]);
            end
            c_op_sub: begin
                w_result = w_diff;
                w_of     = (r_a[31] != r_b[31]) && (w_diff[31] != r_a[31]);
            end
            c_op_slt: w_result = {31'd0, ($signed(r_a) < $signed(r_b))};
            c_op_xor: w_result = r_a ^ r_b;
            c_op_nor: w_result = ~(r_a | r_b);
            c_op_sll: w_result = r_a << r_b[4:0];
            default:  w_result = 32'd0;
        endcase
    end

    // byte_idx is already 0 in HOLD, so the same write path restarts at A[7:0]
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            FOUT     <= 32'd0;
            ZF       <= 1'b0;
            OF       <= 1'b0;
            byte_idx <= 3'd0;
            done     <= 1'b0;
        end else begin
            if (w_capture) begin
                if (byte_idx[2]) begin
                    r_b[{byte_idx[1:0], 3'b000} +: 8] <= din;
                end else begin
                    r_a[{byte_idx[1:0], 3'b000} +: 8] <= din;
                end
                byte_idx <= byte_idx + 3'd1;
                done     <= 1'b0;
            end
            if (w_exec) begin
                FOUT <= w_result;
                ZF   <= (w_result == 32'd0);
                OF   <= w_of;
                done <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_operand_load_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_load_alu
// Description : Directed self-checking bench for operand_load_alu.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_load_alu;

    logic        clk;
    logic        rst;
    logic [7:0]  din;
    logic        load_btn;
    logic [2:0]  alu_op;
    logic [31:0] FOUT;
    logic        ZF;
    logic        OF;
    logic [2:0]  byte_idx;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    operand_load_alu dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .load_btn (load_btn),
        .alu_op   (alu_op),
        .FOUT     (FOUT),
        .ZF       (ZF),
        .OF       (OF),
        .byte_idx (byte_idx),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] b);
        din      = b;
        load_btn = 1'b1;
        step();
        load_btn = 1'b0;
        step();
    endtask

    task automatic load_bytes(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 4; i++) press(a[i*8 +: 8]);
        for (int i = 0; i < 4; i++) press(b[i*8 +: 8]);
    endtask

    task automatic test_reset();
        rst = 1'b1; load_btn = 1'b0; din = 8'h00; alu_op = 3'b000;
        step(); step();
        rst = 1'b0;
        n_checks++; if (FOUT !== 32'd0) $display("FAIL reset_fout got %h exp 0", FOUT); else n_pass++;
        n_checks++; if ({ZF, OF} !== 2'b00) $display("FAIL reset_flags got %b exp 00", {ZF, OF}); else n_pass++;
        n_checks++; if (byte_idx !== 3'd0) $display("FAIL reset_idx got %0d exp 0", byte_idx); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
    endtask

    task automatic test_add_overflow();
        logic [7:0] bytes [8] = '{8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h01, 8'h00, 8'h00, 8'h00};
        alu_op = 3'b010;
        for (int i = 0; i < 7; i++) press(bytes[i]);
        n_checks++; if (byte_idx !== 3'd7) $display("FAIL add_idx7 got %0d exp 7", byte_idx); else n_pass++;
        din = bytes[7]; load_btn = 1'b1;
        step();
        n_checks++; if (done !== 1'b0) $display("FAIL add_lat1_done got %b exp 0", done); else n_pass++;
        n_checks++; if (byte_idx !== 3'd0) $display("FAIL add_wrap got %0d exp 0", byte_idx); else n_pass++;
        load_btn = 1'b0;
        step();
        n_checks++; if (done !== 1'b1) $display("FAIL add_lat2_done got %b exp 1", done); else n_pass++;
        n_checks++; if (FOUT !== 32'h80000000) $display("FAIL add_fout got %h exp 80000000", FOUT); else n_pass++;
        n_checks++; if ({OF, ZF} !== 2'b10) $display("FAIL add_flags got OF,ZF=%b exp 10", {OF, ZF}); else n_pass++;
    endtask

    task automatic test_sub();
        alu_op = 3'b011;
        load_bytes(32'h12345678, 32'h12345678);
        n_checks++; if (FOUT !== 32'd0) $display("FAIL sub_zero_fout got %h exp 0", FOUT); else n_pass++;
        n_checks++; if ({ZF, OF} !== 2'b10) $display("FAIL sub_zero_flags got ZF,OF=%b exp 10", {ZF, OF}); else n_pass++;
        load_bytes(32'h80000000, 32'h00000001);
        n_checks++; if (FOUT !== 32'h7FFFFFFF) $display("FAIL sub_of_fout got %h exp 7fffffff", FOUT); else n_pass++;
        n_checks++; if ({ZF, OF} !== 2'b01) $display("FAIL sub_of_flags got ZF,OF=%b exp 01", {ZF, OF}); else n_pass++;
    endtask

    task automatic test_slt_sll();
        alu_op = 3'b100;
        load_bytes(32'hFFFFFFFF, 32'h00000001);
        n_checks++; if (FOUT !== 32'd1) $display("FAIL slt_fout got %h exp 1", FOUT); else n_pass++;
        alu_op = 3'b111;
        load_bytes(32'hFFFFFFFF, 32'h00000001);
        n_checks++; if (FOUT !== 32'hFFFFFFFE) $display("FAIL sll1_fout got %h exp fffffffe", FOUT); else n_pass++;
        load_bytes(32'h00000001, 32'h00000021);
        n_checks++; if (FOUT !== 32'd2) $display("FAIL sll_mask_fout got %h exp 2", FOUT); else n_pass++;
        n_checks++; if ({ZF, OF} !== 2'b00) $display("FAIL sll_flags got ZF,OF=%b exp 00", {ZF, OF}); else n_pass++;
        alu_op = 3'b100;
        load_bytes(32'h00000005, 32'hFFFFFFFF);
        n_checks++; if (FOUT !== 32'd0 || ZF !== 1'b1) $display("FAIL slt_false got %h zf %b exp 0 zf 1", FOUT, ZF); else n_pass++;
    endtask

    task automatic test_logic_ops();
        alu_op = 3'b000;
        load_bytes(32'hF0F0F0F0, 32'hFF00FF00);
        n_checks++; if (FOUT !== 32'hF000F000) $display("FAIL and_fout got %h exp f000f000", FOUT); else n_pass++;
        alu_op = 3'b101;
        load_bytes(32'hF0F0F0F0, 32'hFF00FF00);
        n_checks++; if (FOUT !== 32'h0FF00FF0) $display("FAIL xor_fout got %h exp 0ff00ff0", FOUT); else n_pass++;
        alu_op = 3'b110;
        load_bytes(32'hF0F0F0F0, 32'hFF00FF00);
        n_checks++; if (FOUT !== 32'h000F000F) $display("FAIL nor_fout got %h exp 000f000f", FOUT); else n_pass++;
        alu_op = 3'b010;
        load_bytes(32'h00001234, 32'h00004321);
        n_checks++; if (FOUT !== 32'h00005555 || OF !== 1'b0) $display("FAIL add_plain got %h of %b exp 00005555 of 0", FOUT, OF); else n_pass++;
    endtask

    task automatic test_held_button();
        rst = 1'b1; step(); rst = 1'b0;
        alu_op = 3'b001;
        din = 8'hAA; load_btn = 1'b1;
        for (int i = 0; i < 10; i++) step();
        n_checks++; if (byte_idx !== 3'd1) $display("FAIL held_idx got %0d exp 1", byte_idx); else n_pass++;
        load_btn = 1'b0; step();
        for (int i = 1; i < 7; i++) press(8'(i));
        // last byte held high straight through the EXEC cycle and into HOLD
        din = 8'h07; load_btn = 1'b1;
        step(); step(); step();
        n_checks++; if (byte_idx !== 3'd0) $display("FAIL exec_idx got %0d exp 0", byte_idx); else n_pass++;
        n_checks++; if (done !== 1'b1) $display("FAIL held_done got %b exp 1", done); else n_pass++;
        n_checks++; if (FOUT !== 32'h070605AE) $display("FAIL held_fout got %h exp 070605ae", FOUT); else n_pass++;
        load_btn = 1'b0; step();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) press(8'h11);
        n_checks++; if (byte_idx !== 3'd5) $display("FAIL mid_idx5 got %0d exp 5", byte_idx); else n_pass++;
        rst = 1'b1; din = 8'h55; load_btn = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (byte_idx !== 3'd0) $display("FAIL mid_rst_idx got %0d exp 0", byte_idx); else n_pass++;
        n_checks++; if (FOUT !== 32'd0) $display("FAIL mid_rst_fout got %h exp 0", FOUT); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL mid_rst_done got %b exp 0", done); else n_pass++;
        step();
        n_checks++; if (byte_idx !== 3'd0) $display("FAIL held_thru_rst got %0d exp 0", byte_idx); else n_pass++;
        load_btn = 1'b0; step();
        alu_op = 3'b001;
        load_bytes(32'h0000000F, 32'h000000F0);
        n_checks++; if (FOUT !== 32'h000000FF) $display("FAIL fresh_or got %h exp 000000ff", FOUT); else n_pass++;
    endtask

    task automatic test_hold_stable();
        int bad = 0;
        for (int i = 0; i < 8; i++) begin
            din = 8'(i * 37);
            alu_op = 3'(i);
            step();
            if (FOUT !== 32'h000000FF || ZF !== 1'b0 || OF !== 1'b0 || done !== 1'b1) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL hold_stable got %0d bad cycles exp 0", bad); else n_pass++;
        press(8'h3C);
        n_checks++; if (done !== 1'b0) $display("FAIL hold_exit_done got %b exp 0", done); else n_pass++;
        n_checks++; if (byte_idx !== 3'd1) $display("FAIL hold_exit_idx got %0d exp 1", byte_idx); else n_pass++;
        n_checks++; if (FOUT !== 32'h000000FF) $display("FAIL hold_exit_fout got %h exp 000000ff", FOUT); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; din = 8'h00; load_btn = 1'b0; alu_op = 3'b000;
        test_reset();
        test_add_overflow();
        test_sub();
        test_slt_sll();
        test_logic_ops();
        test_held_button();
        test_reset_mid();
        test_hold_stable();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
